// File: rtl/qspi_flash_responder.sv
// Quad-SPI NOR flash stand-in (SPI mode 0) serving reads from an external byte-wide memory port.
// Define QSPI_QUAD_READ_EN to decode opcode 0x6B (quad output read with dummy cycles).
module qspi_flash_responder #(
   parameter int          ADDR_W    = 24,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4018,
   parameter int          DUMMY_CYC = 8
) (
   input  logic              mclk,
   input  logic              RESET,
   input  logic              sck,
   input  logic              cs_n,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              busy,
   output logic [7:0]        last_cmd
);
   localparam int CNT_W = 8;
`ifdef QSPI_QUAD_READ_EN
   localparam logic [3:0] OE_MASK = 4'b1111;
`else
   localparam logic [3:0] OE_MASK = 4'b0010;
`endif

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DATA1, ID, IGNORE
`ifdef QSPI_QUAD_READ_EN
      , DUMMY, DATA4
`endif
   } state_t;

   function automatic logic [7:0] id_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         default: id_byte = JEDEC_ID[7:0];
      endcase
   endfunction

   logic              sck_s1_q, sck_s2_q, sck_s3_q;
   logic              cs_s1_q, cs_s2_q, cs_s3_q;
   logic [3:0]        io_s1_q, io_s2_q;
   logic              rise, fall, cs_hi, cs_fall, io0;
   logic              unused_io;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        cmd_sh_q, cmd_sh_d, opcode;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [7:0]        sh_q, sh_d, pf_q, pf_d;
   logic [1:0]        id_idx_q, id_idx_d;
   logic              first_q, first_d, rd_dly_q, rd_dly_d;
   logic [3:0]        io_out_q, io_out_d, oe_q, oe_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_rd_q, mem_rd_d, busy_q, busy_d;
   logic [7:0]        last_cmd_q, last_cmd_d;
`ifdef QSPI_QUAD_READ_EN
   logic              quad_q, quad_d;
`endif

   // Pad synchronizers; only the synced copies are used below.
   always_ff @(posedge mclk) begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      cs_s1_q  <= cs_n;
      cs_s2_q  <= cs_s1_q;
      cs_s3_q  <= cs_s2_q;
      io_s1_q  <= io_in;
      io_s2_q  <= io_s1_q;
   end

   assign rise    = sck_s2_q & ~sck_s3_q;
   assign fall    = ~sck_s2_q & sck_s3_q;
   assign cs_hi   = cs_s2_q;
   assign cs_fall = cs_s3_q & ~cs_s2_q;
   assign io0     = io_s2_q[0];
   // IO1..IO3 are never inputs for the supported commands.
   assign unused_io = ^io_s2_q[3:1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_sh_d   = cmd_sh_q;
      addr_sh_d  = addr_sh_q;
      sh_d       = sh_q;
      pf_d       = pf_q;
      id_idx_d   = id_idx_q;
      first_d    = first_q;
      rd_dly_d   = mem_rd_q;
      io_out_d   = io_out_q;
      oe_d       = oe_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      last_cmd_d = last_cmd_q;
      opcode     = {cmd_sh_q[6:0], io0};
`ifdef QSPI_QUAD_READ_EN
      quad_d     = quad_q;
`endif
      if (cs_hi) begin
         state_d = IDLE;
         cnt_d   = '0;
         oe_d    = '0;
         first_d = 1'b0;
      end else begin
         // Read data returns one mclk after the strobe: first byte goes straight to the shifter.
         if (rd_dly_q) begin
            if (first_q) begin
               sh_d       = mem_data;
               first_d    = 1'b0;
               mem_addr_d = mem_addr_q + 1'b1;
               mem_rd_d   = 1'b1;
            end else begin
               pf_d = mem_data;
            end
         end
         case (state_q)
            IDLE: if (cs_fall) begin
               state_d = CMD;
               cnt_d   = '0;
            end
            CMD: if (rise) begin
               cmd_sh_d = opcode;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(7)) begin
                  last_cmd_d = opcode;
                  cnt_d      = '0;
                  case (opcode)
                     8'h9F: begin
                        state_d  = ID;
                        sh_d     = id_byte(2'd0);
                        id_idx_d = 2'd1;
                        oe_d     = 4'b0010;
                     end
                     8'h03: begin
                        state_d = ADDR;
`ifdef QSPI_QUAD_READ_EN
                        quad_d  = 1'b0;
                     end
                     8'h6B: begin
                        state_d = ADDR;
                        quad_d  = 1'b1;
`endif
                     end
                     default: state_d = IGNORE;
                  endcase
               end
            end
            ADDR: if (rise) begin
               addr_sh_d = {addr_sh_q[ADDR_W-2:0], io0};
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                  cnt_d      = '0;
                  mem_addr_d = {addr_sh_q[ADDR_W-2:0], io0};
                  mem_rd_d   = 1'b1;
                  first_d    = 1'b1;
`ifdef QSPI_QUAD_READ_EN
                  if (quad_q) begin
                     state_d = DUMMY;
                  end else begin
                     state_d = DATA1;
                     oe_d    = 4'b0010;
                  end
`else
                  state_d = DATA1;
                  oe_d    = 4'b0010;
`endif
               end
            end
            DATA1, ID: if (fall) begin
               io_out_d = {2'b00, sh_q[7], 1'b0};
               sh_d     = {sh_q[6:0], 1'b0};
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(7)) begin
                  cnt_d = '0;
                  if (state_q == ID) begin
                     sh_d     = id_byte(id_idx_q);
                     id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                  end else begin
                     sh_d       = pf_q;
                     mem_addr_d = mem_addr_q + 1'b1;
                     mem_rd_d   = 1'b1;
                  end
               end
            end
`ifdef QSPI_QUAD_READ_EN
            DUMMY: if (rise) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                  cnt_d   = '0;
                  state_d = DATA4;
               end
            end
            DATA4: if (fall) begin
               oe_d     = 4'b1111;
               io_out_d = sh_q[7:4];
               sh_d     = {sh_q[3:0], 4'h0};
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  cnt_d      = '0;
                  sh_d       = pf_q;
                  mem_addr_d = mem_addr_q + 1'b1;
                  mem_rd_d   = 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge mclk) begin
      if (RESET) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         rd_dly_q   <= 1'b0;
         io_out_q   <= '0;
         oe_q       <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         last_cmd_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         rd_dly_q   <= rd_dly_d;
         io_out_q   <= io_out_d;
         oe_q       <= oe_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         busy_q     <= busy_d;
         last_cmd_q <= last_cmd_d;
      end
      cmd_sh_q  <= cmd_sh_d;
      addr_sh_q <= addr_sh_d;
      sh_q      <= sh_d;
      pf_q      <= pf_d;
      id_idx_q  <= id_idx_d;
`ifdef QSPI_QUAD_READ_EN
      quad_q    <= quad_d;
`endif
   end

   assign io_out   = io_out_q;
   assign io_oe    = oe_q & OE_MASK;
   assign mem_addr = mem_addr_q;
   assign mem_rd   = mem_rd_q;
   assign busy     = busy_q;
   assign last_cmd = last_cmd_q;
endmodule
